// File: rtl/game_screen_if.sv
// Bundles the keyboard/score inputs and screen-select outputs of the game screen sequencer.
// The master side drives keycode and points; the slave side (the sequencer) drives the screen outputs.
interface game_screen_if #(
  parameter int N_PLAYERS = 2,
  parameter int PTS_W     = 5,
  parameter int SCR_W     = $clog2(N_PLAYERS + 3)
);
  logic [N_PLAYERS*PTS_W-1:0] i_points;
  logic [15:0]                i_keycode;
  logic [SCR_W-1:0]           o_screen;
  logic [1:0]                 o_winner;
  logic                       o_game_run;
  logic                       o_round_clr;

  modport master (
    output i_points, i_keycode,
    input  o_screen, o_winner, o_game_run, o_round_clr
  );

  modport slave (
    input  i_points, i_keycode,
    output o_screen, o_winner, o_game_run, o_round_clr
  );
endinterface

// File: rtl/game_screen_fsm.sv
// Game screen sequencer: turns PS/2 make events and player scores into the
// START / GAME / PAUSE / RESULT(k) screen selection, with registered outputs.
module game_screen_fsm #(
  parameter int         N_PLAYERS   = 2,
  parameter int         PTS_W       = 5,
  parameter int         WIN_POINTS  = 5,
  parameter logic [7:0] KEY_START   = 8'h5A,
  parameter logic [7:0] KEY_PAUSE   = 8'h4D,
  parameter logic [7:0] KEY_RESTART = 8'h2D,
  parameter int         RES_TMO     = 0,
  parameter int         SCR_W       = $clog2(N_PLAYERS + 3)
) (
  input  logic          clk,
  input  logic          rst,
  game_screen_if.slave  bus
);

  localparam int TMO_W = (RES_TMO < 1) ? 1 : $clog2(RES_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((RES_TMO > 0) ? RES_TMO - 1 : 0);

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_GAME   = 2'd1,
    S_PAUSE  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_keycode_q;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [1:0]         r_winner;
  logic [1:0]         w_winner_nxt;
  logic [SCR_W-1:0]   r_screen;
  logic [SCR_W-1:0]   w_screen_nxt;
  logic               r_game_run;
  logic               r_round_clr;

  logic               w_key_evt;
  logic               w_hit_start;
  logic               w_hit_pause;
  logic               w_hit_restart;
  logic               w_tmo_done;
  logic               w_win_any;
  logic [1:0]         w_win_idx;

  // A changed keycode is one event; a break prefix (F0 xx) never is.
  assign w_key_evt     = (bus.i_keycode != r_keycode_q) && (bus.i_keycode[15:8] != 8'hF0);
  assign w_hit_start   = w_key_evt && (bus.i_keycode[7:0] == KEY_START);
  assign w_hit_pause   = w_key_evt && (bus.i_keycode[7:0] == KEY_PAUSE);
  assign w_hit_restart = w_key_evt && (bus.i_keycode[7:0] == KEY_RESTART);
  assign w_tmo_done    = (RES_TMO != 0) && (r_tmo_cnt == TMO_LAST);

  // Scanning from the top index down leaves the lowest winning player in w_win_idx.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer a latch.
    w_win_any = 1'b0;
    w_win_idx = 2'd0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      if (bus.i_points[k*PTS_W +: PTS_W] >= PTS_W'(WIN_POINTS)) begin
        w_win_any = 1'b1;
        w_win_idx = 2'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    case (r_state)
      S_START:  if (w_hit_start) w_state_nxt = S_GAME;
      S_GAME: begin
        if (w_win_any) begin
          w_state_nxt  = S_RESULT;
          w_winner_nxt = w_win_idx;
        end else if (w_hit_pause) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE:  if (w_hit_pause) w_state_nxt = S_GAME;
      S_RESULT: if (w_hit_restart || w_tmo_done) w_state_nxt = S_START;
      default:  w_state_nxt = S_START;
    endcase
  end

  always_comb begin
    w_screen_nxt = '0;
    case (w_state_nxt)
      S_GAME:   w_screen_nxt = SCR_W'(1);
      S_PAUSE:  w_screen_nxt = SCR_W'(2);
      S_RESULT: w_screen_nxt = SCR_W'(3) + SCR_W'(w_winner_nxt);
      default:  w_screen_nxt = '0;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_START;
      r_keycode_q <= '0;
      r_tmo_cnt   <= '0;
      r_winner    <= '0;
      r_screen    <= '0;
      r_game_run  <= 1'b0;
      r_round_clr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      r_state     <= w_state_nxt;
      r_keycode_q <= bus.i_keycode;
      r_winner    <= w_winner_nxt;
      r_screen    <= w_screen_nxt;
      r_game_run  <= (w_state_nxt == S_GAME);
      r_round_clr <= (r_state == S_START) && (w_state_nxt == S_GAME);
      if ((r_state == S_RESULT) && (w_state_nxt == S_RESULT)) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                                                    r_tmo_cnt <= '0;
    end
  end

  assign bus.o_screen    = r_screen;
  assign bus.o_winner    = r_winner;
  assign bus.o_game_run  = r_game_run;
  assign bus.o_round_clr = r_round_clr;

endmodule

// File: tb/tb_game_screen_fsm.sv
// Scoreboard bench for game_screen_fsm with 3 players and an 8-cycle RESULT timeout.
// Expected outputs are queued with each stimulus and checked one cycle later.
module tb_game_screen_fsm;

  localparam int N_PLAYERS = 3;
  localparam int PTS_W     = 5;
  localparam int SCR_W     = $clog2(N_PLAYERS + 3);

  typedef struct {
    string      tag;
    logic [2:0] screen;
    logic [1:0] winner;
    logic       run;
    logic       clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  game_screen_if #(.N_PLAYERS(N_PLAYERS), .PTS_W(PTS_W)) bus ();

  game_screen_fsm #(.N_PLAYERS(N_PLAYERS), .PTS_W(PTS_W), .RES_TMO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic apply(input string tag, input logic r, input logic [15:0] key,
                       input logic [4:0] p2, input logic [4:0] p1, input logic [4:0] p0,
                       input logic [2:0] scr, input logic [1:0] win, input logic run, input logic clr);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.i_keycode = key;
    bus.i_points  = {p2, p1, p0};
    e.tag = tag; e.screen = scr; e.winner = win; e.run = run; e.clr = clr;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".screen"},    32'(bus.o_screen),    32'(mon_e.screen));
      check({mon_e.tag, ".winner"},    32'(bus.o_winner),    32'(mon_e.winner));
      check({mon_e.tag, ".game_run"},  32'(bus.o_game_run),  32'(mon_e.run));
      check({mon_e.tag, ".round_clr"}, 32'(bus.o_round_clr), 32'(mon_e.clr));
    end
  end

  initial begin
    bus.i_keycode = 16'h0000;
    bus.i_points  = '0;

    apply("reset0", 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    apply("reset1", 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    apply("start",  0, 16'h005A, 0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) apply("hold", 0, 16'h005A, 0, 0, 0, 1, 0, 1, 0);
    apply("brk",    0, 16'hF05A, 0, 0, 0, 1, 0, 1, 0);
    apply("rekey",  0, 16'h005A, 0, 0, 0, 1, 0, 1, 0);

    // P1 reaches 5 -> RESULT(1), then auto-return after exactly 8 cycles
    apply("win1",   0, 16'h005A, 2, 5, 1, 4, 1, 0, 0);
    for (int i = 0; i < 7; i++) apply("tmo_wait", 0, 16'h005A, 2, 5, 1, 4, 1, 0, 0);
    apply("tmo_exit",  0, 16'h005A, 2, 5, 1, 0, 1, 0, 0);
    apply("start_brk", 0, 16'hF05A, 0, 0, 0, 0, 1, 0, 0);
    apply("start2",    0, 16'h005A, 0, 0, 0, 1, 1, 1, 1);

    // Tie between P0 and P1 resolves to P0; break code does not leave RESULT
    apply("tie",     0, 16'h005A, 0, 5, 5, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply("brk_res", 0, 16'hF02D, 0, 5, 5, 3, 0, 0, 0);
    apply("restart", 0, 16'h002D, 0, 0, 0, 0, 0, 0, 0);

    // Pause freezes win detection until resumed
    apply("start3",    0, 16'h005A, 0, 0, 0, 1, 0, 1, 1);
    apply("pause",     0, 16'h004D, 0, 0, 0, 2, 0, 0, 0);
    apply("pause_win", 0, 16'h004D, 5, 0, 0, 2, 0, 0, 0);
    apply("pause_brk", 0, 16'hF04D, 5, 0, 0, 2, 0, 0, 0);
    apply("resume",    0, 16'h004D, 5, 0, 0, 1, 0, 1, 0);
    apply("win2",      0, 16'h004D, 5, 0, 0, 5, 2, 0, 0);

    // Restart key on the same cycle as the timeout leaves RESULT once
    for (int i = 0; i < 7; i++) apply("res_wait", 0, 16'h004D, 0, 0, 0, 5, 2, 0, 0);
    apply("both", 0, 16'h002D, 0, 0, 0, 0, 2, 0, 0);
    apply("once", 0, 16'h002D, 0, 0, 0, 0, 2, 0, 0);

    // Win and pause key together: win takes priority
    apply("start4",         0, 16'h005A, 0, 0, 0, 1, 2, 1, 1);
    apply("win_over_pause", 0, 16'h004D, 0, 5, 0, 4, 1, 0, 0);
    apply("res_hold",       0, 16'h004D, 0, 5, 0, 4, 1, 0, 0);
    apply("rst_res",        1, 16'h004D, 0, 5, 0, 0, 0, 0, 0);

    // Reset while paused
    apply("start5",    0, 16'h005A, 0, 0, 0, 1, 0, 1, 1);
    apply("pause2",    0, 16'h004D, 0, 0, 0, 2, 0, 0, 0);
    apply("rst_pause", 1, 16'h004D, 0, 0, 0, 0, 0, 0, 0);
    apply("post_rst",  0, 16'h004D, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
